// File: rtl/seg_mode_sched.sv
// seg_mode_sched: digit-scan timing and display-source scheduler for the
// 8-digit seven-segment stage. Source changes land only on frame edges.
module seg_mode_sched #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DWELL_FRAMES = 1000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       auto_en,
  input  logic [2:0] src_valid,
  input  logic       man_valid,
  input  logic [2:0] man_mode,
  output logic [2:0] mode_seg_en,
  output logic       scan_tick,
  output logic [2:0] digit_idx,
  output logic       frame_end,
  output logic       manual_active
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned DW_W  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

  localparam logic [2:0] MODE_BLANK = 3'b000;
  localparam logic [2:0] MODE_DHT   = 3'b011;
  localparam logic [2:0] MODE_SPD   = 3'b010;
  localparam logic [2:0] MODE_DIST  = 3'b001;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_AUTO   = 2'd1,
    ST_MANUAL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        digit_idx_q, digit_idx_d;
  logic              scan_tick_q, scan_tick_d;
  logic              frame_end_q, frame_end_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [2:0]        mode_q, mode_d;
  logic              manual_q, manual_d;
  logic              pend_q, pend_d;
  logic [2:0]        pend_mode_q, pend_mode_d;

  logic              tick_c;
  logic              frame_edge_c;
  logic [2:0]        v_ord_c;
  logic [1:0]        cur_idx_c;
  logic              cur_ok_c;
  logic              force_c;
  logic              release_c;

  // Rotation position 0/1/2 maps to DHT-11 / speed / distance.
  function automatic logic [2:0] mode_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return MODE_DHT;
      2'd1:    return MODE_SPD;
      default: return MODE_DIST;
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // First valid source scanning the rotation order from start (inclusive).
  function automatic logic [2:0] first_valid(input logic [1:0] start,
                                             input logic [2:0] v_ord);
    logic [2:0] res;
    logic       found;
    logic [1:0] j;
    res   = MODE_BLANK;
    found = 1'b0;
    j     = start;
    for (int k = 0; k < 3; k++) begin
      if (!found && v_ord[j]) begin
        res   = mode_of(j);
        found = 1'b1;
      end
      j = next_idx(j);
    end
    return res;
  endfunction

  // Prescaler, digit scan and strobe generation.
  always_comb begin
    tick_c       = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_edge_c = tick_c && (digit_idx_q == 3'd7);
    cnt_d        = tick_c ? '0 : cnt_q + CNT_W'(1);
    digit_idx_d  = tick_c ? digit_idx_q + 3'd1 : digit_idx_q;
    scan_tick_d  = tick_c;
    frame_end_d  = frame_edge_c;
  end

  // Decode of the current source against its valid bit.
  always_comb begin
    v_ord_c = {src_valid[0], src_valid[1], src_valid[2]};
    case (mode_q)
      MODE_DHT:  begin cur_idx_c = 2'd0; cur_ok_c = src_valid[2]; end
      MODE_SPD:  begin cur_idx_c = 2'd1; cur_ok_c = src_valid[1]; end
      MODE_DIST: begin cur_idx_c = 2'd2; cur_ok_c = src_valid[0]; end
      default:   begin cur_idx_c = 2'd3; cur_ok_c = 1'b0;         end
    endcase
    force_c   = pend_q && (pend_mode_q != MODE_BLANK);
    release_c = pend_q && (pend_mode_q == MODE_BLANK);
  end

  // Mode FSM and pending-request register; transitions only on frame edges.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    dwell_d     = dwell_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;

    if (frame_edge_c) begin
      pend_d = 1'b0;
      case (state_q)
        ST_OFF: begin
          if (force_c) begin
            state_d = ST_MANUAL;
            mode_d  = pend_mode_q;
          end else if (auto_en) begin
            state_d = ST_AUTO;
            dwell_d = '0;
            mode_d  = first_valid(2'd0, v_ord_c);
          end
        end
        ST_AUTO: begin
          if (force_c) begin
            state_d = ST_MANUAL;
            mode_d  = pend_mode_q;
          end else if (!auto_en) begin
            state_d = ST_OFF;
            mode_d  = MODE_BLANK;
            dwell_d = '0;
          end else if (cur_idx_c == 2'd3) begin
            dwell_d = '0;
            mode_d  = first_valid(2'd0, v_ord_c);
          end else if (!cur_ok_c) begin
            dwell_d = '0;
            mode_d  = first_valid(next_idx(cur_idx_c), v_ord_c);
          end else if (dwell_q == DW_W'(DWELL_FRAMES - 1)) begin
            dwell_d = '0;
            mode_d  = first_valid(next_idx(cur_idx_c), v_ord_c);
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
        ST_MANUAL: begin
          if (force_c) begin
            mode_d = pend_mode_q;
          end else if (release_c) begin
            dwell_d = '0;
            if (auto_en) begin
              state_d = ST_AUTO;
              mode_d  = first_valid(2'd0, v_ord_c);
            end else begin
              state_d = ST_OFF;
              mode_d  = MODE_BLANK;
            end
          end
        end
        default: begin
          state_d = ST_OFF;
          mode_d  = MODE_BLANK;
          dwell_d = '0;
        end
      endcase
    end

    // A request arriving on the frame edge itself survives to the next one.
    if (man_valid && !man_mode[2]) begin
      pend_d      = 1'b1;
      pend_mode_d = man_mode;
    end

    manual_d = (state_d == ST_MANUAL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      digit_idx_q <= '0;
      scan_tick_q <= 1'b0;
      frame_end_q <= 1'b0;
      dwell_q     <= '0;
      mode_q      <= MODE_BLANK;
      manual_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_BLANK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_idx_q <= digit_idx_d;
      scan_tick_q <= scan_tick_d;
      frame_end_q <= frame_end_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
      manual_q    <= manual_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
    end
  end

  assign mode_seg_en   = mode_q;
  assign scan_tick     = scan_tick_q;
  assign digit_idx     = digit_idx_q;
  assign frame_end     = frame_end_q;
  assign manual_active = manual_q;

endmodule

// File: tb/tb_seg_mode_sched.sv
// Bench for seg_mode_sched: directed scenarios plus random traffic, all
// cycles checked against a frame-level behavioural model.
module tb_seg_mode_sched;

  localparam int SD = 4;
  localparam int DW = 2;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       auto_en = 1'b0;
  logic [2:0] src_valid = 3'b000;
  logic       man_valid = 1'b0;
  logic [2:0] man_mode = 3'b000;
  logic [2:0] mode_seg_en;
  logic       scan_tick;
  logic [2:0] digit_idx;
  logic       frame_end;
  logic       manual_active;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: edges since reset, and frame-level scheduling state.
  int e = 0;
  int m_state = 0;   // 0 off, 1 auto, 2 manual
  int m_mode = 0;
  int m_dwell = 0;
  bit m_pend = 0;
  int m_pmode = 0;
  bit x_tick = 0;
  bit x_frame = 0;
  int x_digit = 0;
  int order [3] = '{3, 2, 1};

  seg_mode_sched #(.SCAN_DIV(SD), .DWELL_FRAMES(DW)) dut (
    .clk_in(clk_in), .rst(rst), .auto_en(auto_en), .src_valid(src_valid),
    .man_valid(man_valid), .man_mode(man_mode), .mode_seg_en(mode_seg_en),
    .scan_tick(scan_tick), .digit_idx(digit_idx), .frame_end(frame_end),
    .manual_active(manual_active)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  // First valid source in rotation order starting at position start.
  function automatic int first_from(input int start, input logic [2:0] sv);
    for (int k = 0; k < 3; k++) begin
      int m;
      m = order[(start + k) % 3];
      if (sv[m-1]) return m;
    end
    return 0;
  endfunction

  function automatic void enter_auto();
    m_state = 1;
    m_dwell = 0;
    m_mode  = first_from(0, src_valid);
  endfunction

  function automatic void model_edge();
    bit frc, rel;
    if (rst) begin
      e = 0; m_state = 0; m_mode = 0; m_dwell = 0; m_pend = 0; m_pmode = 0;
      x_tick = 0; x_frame = 0; x_digit = 0;
      return;
    end
    e++;
    x_tick  = (e % SD) == 0;
    x_digit = (e / SD) % 8;
    x_frame = x_tick && (x_digit == 0);
    if (x_frame) begin
      frc = m_pend && (m_pmode != 0);
      rel = m_pend && (m_pmode == 0);
      if (frc) begin
        m_state = 2;
        m_mode  = m_pmode;
      end else if (m_state == 0) begin
        if (auto_en) enter_auto();
      end else if (m_state == 1) begin
        if (!auto_en) begin
          m_state = 0; m_mode = 0; m_dwell = 0;
        end else if (m_mode == 0) begin
          m_mode = first_from(0, src_valid); m_dwell = 0;
        end else if (!src_valid[m_mode-1] || m_dwell == DW - 1) begin
          m_mode = first_from(3 - m_mode + 1, src_valid); m_dwell = 0;
        end else begin
          m_dwell++;
        end
      end else if (rel) begin
        if (auto_en) enter_auto();
        else begin m_state = 0; m_mode = 0; m_dwell = 0; end
      end
      m_pend = 0;
    end
    if (man_valid && man_mode < 4) begin
      m_pend = 1;
      m_pmode = man_mode;
    end
  endfunction

  // One clock: model follows the edge, outputs compared 1ns later.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    cyc++;
    check("mode_seg_en", mode_seg_en, m_mode);
    check("scan_tick", scan_tick, x_tick);
    check("digit_idx", digit_idx, x_digit);
    check("frame_end", frame_end, x_frame);
    check("manual_active", manual_active, m_state == 2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic pulse(input logic [2:0] m);
    man_valid = 1'b1;
    man_mode = m;
    step();
    man_valid = 1'b0;
  endtask

  initial begin
    // Rotation through all three sources.
    auto_en = 1'b1; src_valid = 3'b111;
    do_reset();
    check("rst_mode", mode_seg_en, 0);
    check("rst_tick", scan_tick, 0);
    check("rst_digit", digit_idx, 0);
    check("rst_manual", manual_active, 0);
    run_to(3);  check("tick_c3", scan_tick, 0);
    run_to(4);  check("tick_c4", scan_tick, 1);
    run_to(8);  check("tick_c8", scan_tick, 1);
    run_to(31); check("frame_c31", frame_end, 0);
    run_to(32); check("frame_c32", frame_end, 1); check("mode_c32", mode_seg_en, 3);
    run_to(96);  check("mode_c96", mode_seg_en, 2);
    run_to(160); check("mode_c160", mode_seg_en, 1);
    run_to(224); check("mode_c224", mode_seg_en, 3);

    // Two valid sources, then all invalid.
    src_valid = 3'b101;
    do_reset();
    run_to(96); check("v101_c96", mode_seg_en, 1);
    run_to(99); src_valid = 3'b000;
    run_to(127); check("v000_c127", mode_seg_en, 1);
    run_to(128); check("v000_c128", mode_seg_en, 0);

    // Manual force held despite invalid source.
    src_valid = 3'b111;
    do_reset();
    run_to(39); pulse(3'b010); src_valid = 3'b101;
    run_to(63); check("man_c63", mode_seg_en, 3);
    run_to(64); check("man_c64", mode_seg_en, 2); check("man_act_c64", manual_active, 1);
    run_to(384); check("man_hold", mode_seg_en, 2);

    // Last request wins, then release to auto.
    src_valid = 3'b111;
    do_reset();
    run_to(39); pulse(3'b001);
    run_to(49); pulse(3'b011);
    run_to(64); check("last_c64", mode_seg_en, 3); check("last_act", manual_active, 1);
    run_to(69); pulse(3'b000);
    run_to(96); check("rel_c96", mode_seg_en, 3); check("rel_act", manual_active, 0);

    // Auto disabled: illegal request ignored, legal force honoured.
    auto_en = 1'b0;
    do_reset();
    run_to(39); pulse(3'b101);
    run_to(64); check("off_c64", mode_seg_en, 0); check("off_act", manual_active, 0);
    run_to(69); pulse(3'b001);
    run_to(96); check("off_force", mode_seg_en, 1); check("off_force_act", manual_active, 1);

    // Request on the frame edge itself is kept for the next frame.
    auto_en = 1'b1;
    do_reset();
    run_to(63); pulse(3'b001);
    check("edge_c64", mode_seg_en, 3);
    run_to(96); check("edge_c96", mode_seg_en, 1);

    // Mid-frame reset drops the pending request.
    do_reset();
    run_to(45); pulse(3'b010);
    run_to(49);
    do_reset();
    check("mrst_mode", mode_seg_en, 0); check("mrst_digit", digit_idx, 0);
    check("mrst_act", manual_active, 0);
    run_to(3); check("mrst_c3", scan_tick, 0);
    run_to(4); check("mrst_c4", scan_tick, 1);
    run_to(32); check("mrst_c32", mode_seg_en, 3); check("mrst_act32", manual_active, 0);

    // Random traffic against the model.
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(199) == 0) auto_en = ~auto_en;
      if ($urandom_range(59) == 0) src_valid = 3'($urandom_range(7));
      man_valid = ($urandom_range(39) == 0);
      man_mode = 3'($urandom_range(7));
      rst = ($urandom_range(2999) == 0);
      step();
    end
    man_valid = 1'b0;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_mode_sched.md
# seg_mode_sched

Display-mode scheduler for the 8-digit seven-segment output stage.
- Generates the digit-scan strobe and frame boundaries.
- Drives the 3-bit `mode_seg_en` select that picks which source is shown: DHT-11 = 3'b011, speed = 3'b010, distance = 3'b001, blank = 3'b000.
- In automatic mode, rotates through sources whose data is valid; a manual request from the board buttons or UART can override this.
- Mode changes are applied only at frame boundaries, so one scan frame never mixes digits from two sources.

## Interface
Parameters:
- SCAN_DIV, 50000: clk_in cycles per digit slot; legal range 2..2^20.
- DWELL_FRAMES, 1000: complete 8-digit frames each source is shown in auto rotation; legal range 1..2^16.

Ports:
- clk_in  in  1  system clock; one clock domain only.
- rst  in  1  reset, synchronous, active-high.
- auto_en  in  1  level; 1 = automatic rotation allowed.
- src_valid  in  3  per-source data valid: [2] DHT-11, [1] speed, [0] distance.
- man_valid  in  1  one-cycle pulse; samples man_mode.
- man_mode  in  3  requested mode: 011/010/001 = force that source; 000 = release to auto; any other value is ignored.
- mode_seg_en  out  3  registered display-source select.
- scan_tick  out  1  registered one-cycle strobe, once every SCAN_DIV cycles.
- digit_idx  out  3  registered index of the active digit, 0..7.
- frame_end  out  1  registered one-cycle strobe when digit_idx wraps from 7 to 0.
- manual_active  out  1  registered; 1 while in the MANUAL state.

## Operation
- Prescaler `cnt`, width ceil(log2 SCAN_DIV).
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - The edge where cnt==SCAN_DIV-1 is the "tick edge".
- On every tick edge:
  - digit_idx increments modulo 8.
  - scan_tick is registered high for the next cycle.
  - If digit_idx was 7, this is a "frame edge": frame_end is registered high for the next cycle.
- State machine, with all transitions applied only on frame edges:
  - OFF: mode_seg_en=000.
    - Goes to AUTO if auto_en=1.
    - Goes to MANUAL if a manual request is pending.
  - AUTO: runs the rotation described below.
    - Goes to OFF if auto_en=0 and no manual request is pending.
    - A pending force request takes it to MANUAL.
  - MANUAL: mode_seg_en holds the forced value, and src_valid is ignored.
    - A pending release (000) goes to AUTO if auto_en=1, otherwise to OFF.
    - A new pending force changes the displayed mode and stays in MANUAL.
- Pending register:
  - man_valid with a legal man_mode loads the pending value and sets the pending flag.
  - A later request before the frame edge overwrites the earlier one (last wins).
  - The flag clears on the frame edge that consumes it.
  - If man_valid occurs on the frame edge itself, it is held pending for the next frame edge.
- Auto rotation:
  - Order is 011 -> 010 -> 001 -> 011.
  - Dwell counter `dwell` counts frame edges spent in AUTO.
  - When dwell==DWELL_FRAMES-1 on a frame edge, dwell resets to 0 and mode_seg_en advances to the next source in order whose src_valid bit is 1.
  - If the current source is the only valid source, it is kept.
  - If no source is valid, mode_seg_en=000. Rotation resumes at the first valid source in order starting from 011 at the next frame edge where any src_valid bit is 1; dwell is reset at that point.
  - If the currently shown source's valid bit drops, rotation advances to the next valid source at the next frame edge, without waiting for the dwell count.
  - Entering AUTO sets dwell=0 and selects the first valid source in order from 011.

## Timing
- Reset values (after one clk_in edge with rst=1):
  - cnt=0, digit_idx=0, dwell=0, pending flag=0, state=OFF.
  - mode_seg_en=000, scan_tick=0, frame_end=0, manual_active=0.
- First scan_tick goes high SCAN_DIV cycles after the first edge with rst=0.
- First frame_end coincides with the 8th scan_tick.
- mode_seg_en and manual_active change on the frame edge, i.e. in the same cycle frame_end is high.
- Worst-case latency from man_valid to mode_seg_en change is 8*SCAN_DIV cycles.
- rst asserted mid-frame or mid-dwell discards all state and any pending request on that edge.

## Test plan
- SCAN_DIV=4, DWELL_FRAMES=2, auto_en=1, src_valid=111, release reset:
  - scan_tick high on cycles 4, 8, 12, ...
  - frame_end high on cycle 32.
  - mode_seg_en = 011 from cycle 32, 010 from cycle 96, 001 from cycle 160, 011 from cycle 224.
- Same setup with src_valid=101:
  - Rotation is 011 -> 001 -> 011; 010 never appears.
  - Drop src_valid to 000 at cycle 100: mode_seg_en=000 from cycle 128.
- man_valid with man_mode=010 at cycle 40 while in AUTO:
  - mode_seg_en=010 and manual_active=1 at cycle 64.
  - Mode held at 010 across 10 frames even with src_valid[1]=0.
- man_mode=001 at cycle 40, then man_mode=011 at cycle 50:
  - At cycle 64, mode_seg_en=011 (last request wins).
  - man_mode=000 at cycle 70: AUTO from cycle 96, mode 011, manual_active=0.
- auto_en=0 after reset: mode stays 000 and state stays OFF.
  - A man_valid with mode 101 is ignored.
  - A man_valid with mode 001 gives mode_seg_en=001 at the next frame edge.
- Assert rst for 1 cycle at cycle 50 of a running frame:
  - Next cycle: all outputs are at their reset values and the pending request is lost.
  - scan_tick returns SCAN_DIV cycles after rst deasserts.
